// File: rtl/proc_mem_port_arbiter.sv
// rtl/proc_mem_port_arbiter.sv - two-requester memory port arbiter with in-order response routing
//
// Purpose:
//   Shares one downstream memory port between the instruction-memory stream
//   (requester 0) and the data-memory stream (requester 1). Each accepted
//   request pushes its source index into an in-order tag FIFO; each response
//   is steered back to the requester named by the FIFO head. Downstream
//   memory must answer in request order.
//
// Configuration macro:
//   PROC_MEM_ARB_DMEM_PRIO_EN - when defined, requester 1 wins whenever it is
//   valid (fixed priority). When undefined, contention is resolved round-robin.
//   In both modes a request stalled by memreq_rdy = 0 holds the grant (lock).
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   req0_* / req1_*     val/rdy request streams from imem / dmem
//   memreq_*            val/rdy request stream to memory
//   memresp_*           val/rdy response stream from memory
//   resp0_* / resp1_*   val/rdy response streams back to imem / dmem
//   num_outstanding     tag FIFO occupancy (in-flight requests)

package proc_mem_pkg;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

module proc_mem_port_arbiter
    import proc_mem_pkg::*;
#(
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic                                clk,
    input  logic                                reset,

    input  mem_req_4B_t                         req0_msg,
    input  logic                                req0_val,
    output logic                                req0_rdy,

    input  mem_req_4B_t                         req1_msg,
    input  logic                                req1_val,
    output logic                                req1_rdy,

    output mem_req_4B_t                         memreq_msg,
    output logic                                memreq_val,
    input  logic                                memreq_rdy,

    input  mem_resp_4B_t                        memresp_msg,
    input  logic                                memresp_val,
    output logic                                memresp_rdy,

    output mem_resp_4B_t                        resp0_msg,
    output logic                                resp0_val,
    input  logic                                resp0_rdy,

    output mem_resp_4B_t                        resp1_msg,
    output logic                                resp1_val,
    input  logic                                resp1_rdy,

    output logic [$clog2(p_max_outstanding):0]  num_outstanding
);

    localparam int unsigned PTR_W = $clog2(p_max_outstanding);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(p_max_outstanding);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [p_max_outstanding-1:0] tag_q,        tag_d;
    logic [PTR_W-1:0]             wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]             count_q,      count_d;
    logic                         last_grant_q, last_grant_d;
    logic                         lock_q,       lock_d;
    logic                         locked_idx_q, locked_idx_d;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    logic full;
    logic nonempty;
    logic any_val;
    logic policy_grant;
    logic grant;
    logic accept_ok;
    logic push;

    always_comb begin
        full     = (count_q == FULL_CNT);
        nonempty = (count_q != '0);
        any_val  = req0_val | req1_val;

`ifdef PROC_MEM_ARB_DMEM_PRIO_EN
        policy_grant = req1_val;
`else
        // Under contention alternate away from the previous winner; with a
        // single valid requester (or none) that requester is selected.
        policy_grant = (req0_val & req1_val) ? ~last_grant_q : req1_val;
`endif

        // A stalled request keeps its grant so memreq_msg cannot change
        // underneath the memory while it is applying backpressure.
        grant = lock_q ? locked_idx_q : policy_grant;

        // Every val/rdy output is qualified by reset so that nothing
        // handshakes while the block is held in reset.
        memreq_val = any_val & ~full & reset;
        memreq_msg = grant ? req1_msg : req0_msg;

        accept_ok = memreq_rdy & ~full & reset;
        req0_rdy  = accept_ok & ~grant;
        req1_rdy  = accept_ok &  grant;

        push = memreq_val & memreq_rdy;
    end

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    logic head;
    logic head_rdy;
    logic pop;

    always_comb begin
        head     = tag_q[rd_ptr_q];
        head_rdy = head ? resp1_rdy : resp0_rdy;

        // With an empty FIFO the response is refused outright; this also
        // rules out accepting a response in the cycle its request is pushed.
        memresp_rdy = head_rdy & nonempty & reset;
        resp0_val   = memresp_val & nonempty & reset & ~head;
        resp1_val   = memresp_val & nonempty & reset &  head;
        resp0_msg   = memresp_msg;
        resp1_msg   = memresp_msg;

        pop = memresp_val & memresp_rdy;
    end

    assign num_outstanding = count_q;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;

        if (push) begin
            tag_d[wr_ptr_q] = grant;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            last_grant_d    = grant;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Simultaneous push and pop cancel out.
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (push) begin
            lock_d = 1'b0;
        end else if (memreq_val & ~memreq_rdy) begin
            lock_d       = 1'b1;
            locked_idx_d = grant;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            // Starting at 1 lets requester 0 win the first tie.
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            locked_idx_q <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
        end
    end

endmodule
